// File: rtl/param_fifo_mem.sv
// Storage array for param_fifo: one write port, one registered read port.
// No reset on the array or the read register; the top masks d_out until the first pop.
module param_fifo_mem #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // On a simultaneous write and read of the same slot, the read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with a registered read port and status flags.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module param_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [W-1:0]  d_in,
    output logic          full,
    input  logic          rd_en,
    output logic [W-1:0]  d_out,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem_rdata;
    logic         have_data;
    logic         we_ok;
    logic         re_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A write while full is allowed only when a pop frees the slot it lands in.
    assign we_ok = wr_en && (!full || rd_en);
    assign re_ok = rd_en && !empty;

    param_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (d_in),
        .re    (re_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    // The read register has no reset, so d_out shows zero until the first pop after reset.
    assign d_out = have_data ? mem_rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            have_data <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            if (we_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (re_ok) begin
                rd_ptr    <= rd_ptr + 1'b1;
                have_data <= 1'b1;
            end
            rd_valid <= re_ok;
            unique case ({we_ok, re_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !rd_en) begin
                ovf <= 1'b1;
            end
            if (rd_en && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (W=8, DEPTH=8).
// Expected values are hand-computed constants plus a queue model for the wrap phase.
module tb_param_fifo;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          resetn;
    logic          wr_en;
    logic [W-1:0]  d_in;
    logic          full;
    logic          rd_en;
    logic [W-1:0]  d_out;
    logic          rd_valid;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;

    int vectors     = 0;
    int miscompares = 0;

    param_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .d_in     (d_in),
        .full     (full),
        .rd_en    (rd_en),
        .d_out    (d_out),
        .rd_valid (rd_valid),
        .empty    (empty),
        .count    (count),
        .ovf      (ovf),
        .udf      (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        wr_en = 1'b1; rd_en = 1'b0; d_in = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [W-1:0] exp);
        rd_en = 1'b1; wr_en = 1'b0;
        tick();
        rd_en = 1'b0;
        check_val({tag, "_dout"}, d_out, exp);
        check_val({tag, "_vld"}, rd_valid, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_empty"}, empty, 1);
        check_val({tag, "_full"},  full, 0);
        check_val({tag, "_count"}, count, 0);
        check_val({tag, "_dout"},  d_out, 0);
        check_val({tag, "_vld"},   rd_valid, 0);
        check_val({tag, "_ovf"},   ovf, 0);
        check_val({tag, "_udf"},   udf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] exp_word;
        int           next_val;
        int           sent;
        int           guard;
        logic         w;
        logic         r;
        logic         we_exp;
        logic         re_exp;

        resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            d_in  = W'($urandom);
            tick();
            check_reset_state("rst");
        end
        wr_en = 1'b0; rd_en = 1'b0;
        resetn = 1'b1;
        tick();

        // Fill with 0x01..0x08.
        for (int i = 1; i <= DEPTH; i++) begin
            push(W'(i));
            check_val("fill_count", count, i);
        end
        check_val("fill_full", full, 1);
        check_val("fill_empty", empty, 0);

        // Overflow: write 0xAA while full, no read.
        push(8'hAA);
        check_val("ovf_flag", ovf, 1);
        check_val("ovf_count", count, 8);
        check_val("ovf_full", full, 1);

        // Drain 0x01..0x08; 0xAA must never appear.
        for (int i = 1; i <= DEPTH; i++) begin
            pop_check("drain", W'(i));
        end
        check_val("drain_empty", empty, 1);
        check_val("drain_count", count, 0);
        tick();
        check_val("idle_vld", rd_valid, 0);
        check_val("idle_hold", d_out, 8'h08);

        // Underflow: read while empty.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("udf_flag", udf, 1);
        check_val("udf_vld", rd_valid, 0);
        check_val("udf_dout", d_out, 8'h08);
        check_val("udf_count", count, 0);

        // Simultaneous read and write while full.
        for (int i = 0; i < DEPTH; i++) begin
            push(W'(8'h10 + i));
        end
        check_val("sim_prefull", full, 1);
        wr_en = 1'b1; rd_en = 1'b1; d_in = 8'h99;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_val("sim_dout", d_out, 8'h10);
        check_val("sim_vld", rd_valid, 1);
        check_val("sim_count", count, 8);
        check_val("sim_full", full, 1);
        check_val("sim_ovf", ovf, 1);
        for (int i = 1; i < DEPTH; i++) begin
            pop_check("sim_drain", W'(8'h10 + i));
        end
        pop_check("sim_last", 8'h99);
        check_val("sim_empty", empty, 1);

        // Read and write together while empty: write only, no write-through.
        wr_en = 1'b1; rd_en = 1'b1; d_in = 8'h55;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check_val("ew_count", count, 1);
        check_val("ew_vld", rd_valid, 0);
        check_val("ew_dout", d_out, 8'h99);
        pop_check("ew_read", 8'h55);

        // Wrap: stream 3*DEPTH words with random gaps against a queue model.
        next_val = 8'h40;
        sent = 0;
        guard = 0;
        while ((sent < 3 * DEPTH || q.size() > 0) && guard < 2000) begin
            guard++;
            w = (sent < 3 * DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 2) != 0);
            we_exp = w && (q.size() < DEPTH || r);
            re_exp = r && (q.size() > 0);
            wr_en = w; rd_en = r; d_in = W'(next_val);
            exp_word = '0;
            if (re_exp) begin
                exp_word = q.pop_front();
            end
            if (we_exp) begin
                q.push_back(W'(next_val));
                next_val++;
                sent++;
            end
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            check_val("wrap_vld", rd_valid, re_exp);
            if (re_exp) begin
                check_val("wrap_dout", d_out, exp_word);
            end
            check_val("wrap_count", count, q.size());
        end
        check_val("wrap_done", (guard < 2000), 1);
        check_val("wrap_empty", empty, 1);

        // Reset mid-stream takes effect without a clock edge.
        push(8'h21);
        push(8'h22);
        push(8'h23);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_state("mid_rst");
        tick();
        resetn = 1'b1;
        tick();
        push(8'h3C);
        push(8'hC3);
        check_val("post_count", count, 2);
        pop_check("post_a", 8'h3C);
        pop_check("post_b", 8'hC3);
        check_val("post_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
- Parameterised synchronous FIFO that buffers words ahead of the data register stage.
- The producer writes with wr_en. The consumer pops with rd_en and receives the word on d_out one cycle later, ready for capture by the downstream register.
- Provides full, empty and occupancy status, plus sticky overflow and underflow error flags.

Parameters:
- W, 8, data word width in bits (W >= 1).
- DEPTH, 8, number of storage entries; power of two, DEPTH >= 2.
- AW (localparam), $clog2(DEPTH), storage address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- d_in  input  W  write data.
- full  output  1  FIFO holds DEPTH words.
- rd_en  input  1  read (pop) request.
- d_out  output  W  read data, registered.
- rd_valid  output  1  d_out was updated by a pop this cycle.
- empty  output  1  FIFO holds 0 words.
- count  output  AW+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky: a write was dropped.
- udf  output  1  sticky: a read was ignored.

Behaviour:
- Reset (resetn low, asynchronous assert):
  - d_out = 0, rd_valid = 0, empty = 1, full = 0, count = 0, ovf = 0, udf = 0.
  - Read and write pointers = 0. Storage array is not reset.
- Deassertion is synchronous to clk; the upstream synchroniser guarantees this.
- Pointers are AW+1 bits wide and wrap naturally modulo 2*DEPTH.
  - empty: pointers are equal.
  - full: MSBs differ and the low AW bits are equal.
- Accepted write, we_ok = wr_en & (!full | rd_en):
  - Stores d_in at wr_ptr[AW-1:0] and increments wr_ptr.
- Accepted read, re_ok = rd_en & !empty:
  - Next edge: d_out <= mem[rd_ptr[AW-1:0]], rd_ptr increments, rd_valid = 1.
  - Read latency is exactly 1 cycle from the rd_en sample to valid d_out.
- No accepted read: d_out holds its last value and rd_valid = 0.
- Simultaneous events:
  - Read and write on a non-empty FIFO: both accepted, count unchanged.
  - Read and write while full: both accepted, and the write lands in the slot being freed. The read returns the old word; there is no bypass.
  - Read and write while empty: the write is accepted, the read is ignored and udf sets. No write-through to d_out.
- count next state: +1 on write only, -1 on read only, unchanged on both or neither. count, full and empty are registered, or derived from registered pointers with no input-to-output combinational path.
- Error flags:
  - wr_en & full & !rd_en sets ovf; the write is dropped and state is unchanged.
  - rd_en & empty sets udf.
  - Both flags clear only on reset.
- Reset during operation: contents are discarded and the FIFO returns to the empty state immediately.

Decomposition:
- No shared package is needed. Pointer width is derived locally from DEPTH via $clog2.
- Sub-module param_fifo_mem:
  - DEPTH x W array, single write port and single synchronous read port, no reset.
  - The top level holds pointers, flags, count and the d_out/rd_valid handling.

Test Plan:
- Reset: hold resetn = 0 with random inputs -> empty = 1, full = 0, count = 0, d_out = 0, ovf = udf = 0.
- Fill then drain:
  - Write 0x01..0x08 on consecutive cycles -> full = 1 and count = 8 after the 8th edge.
  - Then assert rd_en for 8 cycles -> d_out = 0x01..0x08 in order, each one cycle after its rd_en, and empty = 1 at the end.
- Overflow: when full, write 0xAA without a read -> ovf = 1, count stays 8, and the later drain never returns 0xAA.
- Underflow: rd_en while empty -> udf = 1, rd_valid = 0, d_out unchanged, count stays 0.
- Simultaneous read and write:
  - Full with 0x10..0x17, read and write 0x99 together -> d_out = 0x10, count = 8, full = 1.
  - Drain the remainder -> 0x11..0x17 then 0x99.
- Wrap and mid-reset:
  - Stream 3*DEPTH words with random push/pop gaps -> order is preserved across pointer wrap.
  - Assert resetn low mid-stream -> the reset state appears without waiting for a clock, and subsequent writes read back correctly.
